// File: rtl/prio_enc_pkg.sv
// Shared sizing constants for the registered 4-to-2 priority encoder.
package prio_enc_pkg;

    localparam int N_IN   = 4;
    localparam int CODE_W = 2;

    localparam logic [CODE_W-1:0] CODE_NONE = 2'b00;

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority encode: index of the highest set request bit plus any-set flag.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter int N_IN_P   = N_IN,
    parameter int CODE_W_P = (N_IN_P > 1) ? $clog2(N_IN_P) : 1
) (
    input  logic [N_IN_P-1:0]   req,
    output logic [CODE_W_P-1:0] code_next,
    output logic                valid_next
);

    // Scan upward so each later (higher) set bit overwrites the code.
    always_comb begin
        code_next  = CODE_W_P'(CODE_NONE);
        valid_next = 1'b0;
        for (int i = 0; i < N_IN_P; i++) begin
            if (req[i]) begin
                code_next  = CODE_W_P'(i);
                valid_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_4to2.sv
// Registered 4-input priority encoder; outputs come straight from flops.
module priority_encoder_4to2
    import prio_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   in,
    output logic [CODE_W-1:0] code,
    output logic              valid
);

    logic [CODE_W-1:0] code_next;
    logic              valid_next;
    logic [CODE_W-1:0] code_reg;
    logic              valid_reg;

    prio_enc_core #(
        .N_IN_P   (N_IN),
        .CODE_W_P (CODE_W)
    ) u_core (
        .req        (in),
        .code_next  (code_next),
        .valid_next (valid_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            code_reg  <= CODE_NONE;
            valid_reg <= 1'b0;
        end else begin
            code_reg  <= code_next;
            valid_reg <= valid_next;
        end
    end

    assign code  = code_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Directed self-checking bench for priority_encoder_4to2.
module tb_priority_encoder_4to2;

    logic       clk;
    logic       rst;
    logic [3:0] in;
    logic [1:0] code;
    logic       valid;

    int n_cmp;
    int n_bad;

    priority_encoder_4to2 dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .code  (code),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference written as a casez table, independent of the loop in the core.
    function automatic logic [2:0] ref_enc(input logic [3:0] v);
        casez (v)
            4'b1???: ref_enc = 3'b1_11;
            4'b01??: ref_enc = 3'b1_10;
            4'b001?: ref_enc = 3'b1_01;
            4'b0001: ref_enc = 3'b1_00;
            default: ref_enc = 3'b0_00;
        endcase
    endfunction

    // Apply one input, take one edge, settle past it.
    task automatic step(input logic r, input logic [3:0] v);
        rst = r;
        in  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 4'b1111);
            n_cmp++;
            $display("txn reset edge%0d in=%b -> valid=%b code=%b", k, in, valid, code);
            if ({valid, code} !== 3'b0_00) begin
                n_bad++;
                $display("FAIL reset_hold%0d: got valid/code=%b, want 000", k, {valid, code});
            end
        end
        step(1'b0, 4'b1111);
        n_cmp++;
        $display("txn reset release in=%b -> valid=%b code=%b", in, valid, code);
        if ({valid, code} !== 3'b1_11) begin
            n_bad++;
            $display("FAIL reset_release: got valid/code=%b, want 111", {valid, code});
        end
    endtask

    task automatic test_empty();
        step(1'b0, 4'b0000);
        n_cmp++;
        $display("txn empty in=%b -> valid=%b code=%b", in, valid, code);
        if ({valid, code} !== 3'b0_00) begin
            n_bad++;
            $display("FAIL empty_after_11: got valid/code=%b, want 000", {valid, code});
        end
    endtask

    task automatic test_thermometer();
        logic [3:0] vin [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        logic [2:0] exp [4] = '{3'b1_00, 3'b1_01, 3'b1_10, 3'b1_11};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, vin[k]);
            n_cmp++;
            $display("txn thermo in=%b -> valid=%b code=%b", in, valid, code);
            if ({valid, code} !== exp[k]) begin
                n_bad++;
                $display("FAIL thermo%0d in=%b: got valid/code=%b, want %b", k, vin[k], {valid, code}, exp[k]);
            end
        end
    endtask

    task automatic test_priority_mask();
        logic [3:0] vin [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b1010, 4'b0110, 4'b1001};
        logic [2:0] exp [6] = '{3'b1_11, 3'b1_10, 3'b1_01, 3'b1_11, 3'b1_10, 3'b1_11};
        for (int k = 0; k < 6; k++) begin
            step(1'b0, vin[k]);
            n_cmp++;
            $display("txn mask in=%b -> valid=%b code=%b", in, valid, code);
            if ({valid, code} !== exp[k]) begin
                n_bad++;
                $display("FAIL mask%0d in=%b: got valid/code=%b, want %b", k, vin[k], {valid, code}, exp[k]);
            end
        end
    endtask

    task automatic test_exhaustive();
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 4'(k));
            n_cmp++;
            $display("txn exh in=%b -> valid=%b code=%b", in, valid, code);
            if ({valid, code} !== ref_enc(4'(k))) begin
                n_bad++;
                $display("FAIL exh in=%b: got valid/code=%b, want %b", 4'(k), {valid, code}, ref_enc(4'(k)));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] v;
        for (int k = 0; k < 6; k++) begin
            v = 4'($urandom_range(1, 15));
            step(1'b0, v);
            n_cmp++;
            $display("txn stream in=%b -> valid=%b code=%b", in, valid, code);
            if ({valid, code} !== ref_enc(v)) begin
                n_bad++;
                $display("FAIL stream%0d in=%b: got valid/code=%b, want %b", k, v, {valid, code}, ref_enc(v));
            end
        end
        step(1'b1, 4'b1100);
        n_cmp++;
        $display("txn midrst in=%b -> valid=%b code=%b", in, valid, code);
        if ({valid, code} !== 3'b0_00) begin
            n_bad++;
            $display("FAIL mid_reset: got valid/code=%b, want 000", {valid, code});
        end
        step(1'b0, 4'b1100);
        n_cmp++;
        $display("txn resume in=%b -> valid=%b code=%b", in, valid, code);
        if ({valid, code} !== 3'b1_11) begin
            n_bad++;
            $display("FAIL resume: got valid/code=%b, want 111", {valid, code});
        end
        step(1'b0, 4'b0010);
        n_cmp++;
        $display("txn resume2 in=%b -> valid=%b code=%b", in, valid, code);
        if ({valid, code} !== 3'b1_01) begin
            n_bad++;
            $display("FAIL resume2: got valid/code=%b, want 101", {valid, code});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        in    = 4'b0000;
        #1;
        test_reset();
        test_empty();
        test_thermometer();
        test_priority_mask();
        test_exhaustive();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/priority_encoder_4to2.md
Name: priority_encoder_4to2

Overview:
- Registered 4-input priority encoder: reports the index of the highest-numbered asserted request bit, plus a valid flag that is high when any bit is set.
- Used as a request-to-index stage in front of arbitration or selection logic.
- Combinational encode is followed by one output register stage on a single clock with synchronous active-high reset.

Parameters:
- N_IN, 4, number of request inputs; fixed at 4 for this block, exposed for reuse of the core.
- CODE_W, 2, width of the code output, equal to clog2(N_IN).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- in  input  4  request vector; bit 3 has highest priority, bit 0 lowest.
- code  output  2  registered index of the highest-priority set bit.
- valid  output  1  registered flag, 1 when any bit of in was set.

Behaviour:
- One clock on clk. Reset is synchronous and active-high.
- Reset: when rst is high at a rising clk edge, code <= 2'b00 and valid <= 0. Reset takes precedence over input sampling in that cycle.
- Latency: in is sampled on each rising clk edge with rst low. code and valid reflect that sample immediately after the edge, and hold until the next edge.
- Priority rule, highest index wins; lower bits are don't-care:
  - in[3]=1 -> code 3, valid 1.
  - in[3:2]=01 -> code 2, valid 1.
  - in[3:1]=001 -> code 1, valid 1.
  - in=0001 -> code 0, valid 1.
  - in=0000 -> code 0, valid 0. The code value is forced to 00, not held from the previous cycle.
- Outputs are driven only from flops; there is no combinational path from in to code or valid.
- X/Z on in is not handled specially. The bench drives only known values.
- Reset asserted mid-stream clears both outputs at the next edge. The first edge after reset deasserts resumes normal encoding of in.
- Back-to-back input changes every cycle must each produce the matching output one cycle later; there are no stalls and no handshake.

Decomposition:
- Shared package prio_enc_pkg:
  - N_IN = 4 and CODE_W = 2.
  - Constant CODE_NONE = 2'b00, the code value driven when no bit is set.
- One sub-module, prio_enc_core:
  - Purely combinational, parameterised by N_IN.
  - Loop from low to high index so the highest set bit wins.
  - Produces the next code and next valid.
- Top level priority_encoder_4to2: instantiates prio_enc_core and adds the output registers with synchronous reset.

Test Plan:
- Reset: hold rst=1 with in=4'b1111 for 2 edges -> code=00, valid=0. Release rst; after the next edge -> code=11, valid=1.
- Empty input: in=0000 -> after the next edge, valid=0 and code=00, including when the previous code was 11.
- Thermometer sweep: drive in = 0001, 0011, 0111, 1111 on consecutive edges -> codes 00, 01, 10, 11, each with valid=1, each one cycle after its input.
- Priority masking: in = 1000, 0100, 0010, 1010, 0110, 1001 -> codes 11, 10, 01, 11, 10, 11, all with valid=1.
- Exhaustive: all 16 values of in, checked one cycle later against a behavioural model (highest set index; valid = OR of bits).
- Mid-operation reset: stream random inputs, assert rst for one edge -> outputs 00/0 for that cycle only. The next cycle encodes the current in correctly.
